// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: core stores feed a small TX FIFO that a
// serializer drains onto tx at a programmable bit period (BAUDDIV).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (tx=0) for div_lat cycles
// S_DATA  | 8 data bits LSB first, div_lat cycles each
// S_STOP  | stop bit (tx=1); last cycle chains into the next frame
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        idle
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        sel;
    logic [1:0]  idx;
    logic        wr_data;
    logic        wr_stat;
    logic        wr_div;

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        drop;

    logic        ovf;
    logic [15:0] div;
    logic [15:0] div_lat;
    logic [15:0] cyc_cnt;
    logic [15:0] bit_cnt;
    logic [7:0]  shreg;
    logic        bit_done;
    logic        busy;

    logic        unused_bits;
    assign unused_bits = ^{A[1:0], WD[31:16]};

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    assign sel     = (A[31:4] == BASE_ADDR[31:4]);
    assign idx     = A[3:2];
    assign wr_data = WE && sel && (idx == 2'd0);
    assign wr_stat = WE && sel && (idx == 2'd1);
    assign wr_div  = WE && sel && (idx == 2'd2);

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign bit_done = (cyc_cnt == div_lat - 16'd1);

    // A pop frees a slot in the same cycle, so a store into a full FIFO still lands.
    assign pop  = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
    assign push = wr_data && (!full || pop);
    assign drop = wr_data && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr[AW-1:0]] <= WD[7:0];
    end

    // ---------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (wr_stat && WD[3]) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= DIV_RST;
        end else if (wr_div) begin
            div <= (WD[15:0] == 16'd0) ? 16'd1 : WD[15:0];
        end
    end

    // ---------------------------------------------------------------
    // Serializer FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_START;
            S_START: if (bit_done) state_nx = S_DATA;
            S_DATA:  if (bit_done && (bit_cnt == 16'd7)) state_nx = S_STOP;
            S_STOP:  if (bit_done) state_nx = empty ? S_IDLE : S_START;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign idle = empty && !busy;

    // Divisor is sampled at every pop so a mid-frame BAUDDIV write waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            div_lat <= DIV_RST;
        end else if (pop) begin
            shreg   <= mem[rptr[AW-1:0]];
            div_lat <= div;
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else if (state != S_IDLE) begin
            if (bit_done) begin
                cyc_cnt <= '0;
                if (state == S_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 16'd1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Combinational read path
    // ---------------------------------------------------------------
    always_comb begin
        RD = '0;
        if (sel) begin
            case (idx)
                2'd1:    RD = {28'b0, ovf, busy, empty, full};
                2'd2:    RD = {16'b0, div};
                default: RD = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame shape, FIFO overflow,
// divisor latching, reset abort and address decode.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WE  = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] WD  = '0;
    logic [31:0] RD;
    logic        tx;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    bit cap_en = 1'b0;
    int cap_n  = 0;
    bit cap_tx   [1024];
    bit cap_idle [1024];
    bit exp_tx   [1024];
    bit exp_idle [1024];
    int exp_n  = 0;

    uart_tx_mmio #(
        .BASE_ADDR   (32'h0000_1000),
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .WE  (WE),
        .A   (A),
        .WD  (WD),
        .RD  (RD),
        .tx  (tx),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // Record line and idle state shortly after each rising edge while enabled.
    always @(posedge clk) begin
        #2;
        if (cap_en && cap_n < 1024) begin
            cap_tx[cap_n]   = tx;
            cap_idle[cap_n] = idle;
            cap_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
        A  = '0;
        WD = '0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] val);
        WE = 1'b0;
        A  = addr;
        #1;
        val = RD;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cap();
        cap_n  = 0;
        exp_n  = 0;
        cap_en = 1'b1;
    endtask

    task automatic add_bits(input bit v, input int n, input bit idl);
        for (int i = 0; i < n; i++) begin
            exp_tx[exp_n]   = v;
            exp_idle[exp_n] = idl;
            exp_n++;
        end
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        add_bits(1'b0, d, 1'b0);
        for (int i = 0; i < 8; i++) add_bits(b[i], d, 1'b0);
        add_bits(1'b1, d, 1'b0);
    endtask

    task automatic check_stream(input string tag);
        int bound;
        int e0;
        bound = 0;
        while (cap_n < exp_n && bound < 3000) begin
            @(negedge clk);
            bound++;
        end
        cap_en = 1'b0;
        chk({tag, "_len"}, 32'(cap_n >= exp_n), 32'd1);
        e0 = n_err;
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_tx[%0d]", tag, i), 32'(cap_tx[i]), 32'(exp_tx[i]));
            chk($sformatf("%s_idle[%0d]", tag, i), 32'(cap_idle[i]), 32'(exp_idle[i]));
            if (n_err != e0) break;
        end
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(32'h1004, v); chk("rst_status", v, 32'h2);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        rd(32'h1008, v); chk("rst_div", v, 32'd16);
        rd(32'h1000, v); chk("txdata_read", v, 32'd0);
        @(negedge clk);

        // Single frame 0x55 at div=4
        store(32'h1008, 32'd4);
        rd(32'h1008, v); chk("div4", v, 32'd4);
        @(negedge clk);
        start_cap();
        store(32'h1000, 32'h55);
        chk("store_idle_low", 32'(idle), 32'd0);
        chk("store_tx_high", 32'(tx), 32'd1);
        add_bits(1'b1, 1, 1'b0);
        add_frame(8'h55, 4);
        add_bits(1'b1, 1, 1'b1);
        check_stream("f55");

        // Five rapid stores at div=2, then two overflowing stores
        store(32'h1008, 32'd2);
        start_cap();
        A  = 32'h1000;
        WE = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            WD = 32'(i);
            @(negedge clk);
        end
        WE = 1'b0;
        rd(32'h1004, v); chk("burst_full", v, 32'h5);
        @(negedge clk);
        store(32'h1000, 32'h06);
        store(32'h1000, 32'h07);
        rd(32'h1004, v); chk("burst_ovf", v, 32'hD);
        add_bits(1'b1, 1, 1'b0);
        for (int b = 1; b <= 5; b++) add_frame(8'(b), 2);
        add_bits(1'b1, 1, 1'b1);
        check_stream("burst");
        rd(32'h1004, v); chk("ovf_sticky", v, 32'hA);
        @(negedge clk);
        store(32'h1004, 32'h8);
        rd(32'h1004, v); chk("ovf_clear", v, 32'h2);
        @(negedge clk);

        // Mid-frame divisor change applies to the next frame only
        store(32'h1008, 32'd4);
        start_cap();
        store(32'h1000, 32'hF0);
        wait_cyc(10);
        store(32'h1008, 32'd3);
        store(32'h1000, 32'h0F);
        add_bits(1'b1, 1, 1'b0);
        add_frame(8'hF0, 4);
        add_frame(8'h0F, 3);
        add_bits(1'b1, 1, 1'b1);
        check_stream("divchg");
        rd(32'h1008, v); chk("div3", v, 32'd3);
        @(negedge clk);

        // Divisor 0 is stored as 1
        store(32'h1008, 32'd0);
        rd(32'h1008, v); chk("div0_as_1", v, 32'd1);
        @(negedge clk);
        start_cap();
        store(32'h1000, 32'h5A);
        add_bits(1'b1, 1, 1'b0);
        add_frame(8'h5A, 1);
        add_bits(1'b1, 1, 1'b1);
        check_stream("div1");

        // Reset during DATA bits of 0xA3; coinciding store ignored
        store(32'h1008, 32'd4);
        store(32'h1000, 32'hA3);
        wait_cyc(13);
        chk("pre_rst_bit2", 32'(tx), 32'd0);
        rst = 1'b1;
        A   = 32'h1000;
        WD  = 32'h77;
        WE  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        WE  = 1'b0;
        chk("rst_abort_tx", 32'(tx), 32'd1);
        chk("rst_abort_idle", 32'(idle), 32'd1);
        rd(32'h1004, v); chk("rst_abort_status", v, 32'h2);
        rd(32'h1008, v); chk("rst_abort_div", v, 32'd16);
        @(negedge clk);
        start_cap();
        add_bits(1'b1, 50, 1'b1);
        check_stream("post_rst");

        // Out-of-window and reserved accesses
        start_cap();
        store(32'h2000, 32'h99);
        rd(32'h100C, v); chk("reserved_read", v, 32'd0);
        @(negedge clk);
        store(32'h100C, 32'h41);
        rd(32'h2004, v); chk("outside_read", v, 32'd0);
        rd(32'h1004, v); chk("decode_status", v, 32'h2);
        @(negedge clk);
        add_bits(1'b1, 20, 1'b1);
        check_stream("decode");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
